mem_slot_sched: RTL and testbench
=================================

// Module: mem_slot_sched
// PURPOSE
//  Memory-cycle scheduler for the video/RAM bus. Divides m2clock into fixed SLOT_CLKS slots and grants each
//  slot to one owner: video fetch, DRAM refresh, DMA or CPU. Uses display-enable timing (de, ihsync, mde1)
//  so the shifter never starves while DE is active. Sits beside the horizontal DE generator in the MCU.
// PARAMETERS
//  SLOT_CLKS  4  m2clock cycles per memory slot (power of 2, >=2)
//  REF_MAX    3  saturation value of the pending-refresh counter; at REF_MAX refresh is urgent
// PORTS
//  m2clock    in   1  system clock; all logic on posedge
//  por        in   1  asynchronous, active-high reset
//  de         in   1  display enable (horizontal & vertical), sampled at slot start
//  mde1       in   1  1 = mono/high-res: video eligible every slot; 0 = video eligible on even slots only
//  ihsync     in   1  horizontal sync; each rising edge adds one pending refresh
//  dma_req    in   1  DMA request; held high until dma_ack
//  cpu_req    in   1  CPU request; held high until cpu_ack
//  slot_start out  1  1-clock pulse at phase 0 of every slot
//  owner      out  2  current slot owner: 0 idle, 1 video, 2 refresh, 3 DMA/CPU (see dma_sel)
//  dma_sel    out  1  with owner==3: 1 = DMA, 0 = CPU
//  vid_load   out  1  1-clock pulse at the last phase of a video slot (shifter word latch)
//  ref_grant  out  1  high for the whole refresh slot
//  dma_ack    out  1  1-clock pulse at the last phase of a DMA slot
//  cpu_ack    out  1  1-clock pulse at the last phase of a CPU slot
//  ref_pend   out  2  pending-refresh count
// BEHAVIOUR
//  - Reset (por=1, async): phase=0, slot parity=0, owner=0, dma_sel=0, ref_pend=0, ihsync edge flop=0,
//    all pulse outputs 0. Reset mid-slot aborts the slot; no ack or vid_load is issued for it.
//  - Phase counter: free-running 0..SLOT_CLKS-1, wraps to 0. Slot parity toggles on each wrap.
//    slot_start = (phase==0).
//  - Arbitration: evaluated combinationally in the cycle phase==SLOT_CLKS-1 and registered, so the owner
//    is valid from phase 0 of the next slot and held constant for the whole slot. Priority:
//    1 video:   de & (mde1 | next parity even)
//    2 refresh: ref_pend==REF_MAX (urgent)
//    3 DMA:     dma_req
//    4 refresh: ref_pend!=0 & ~de
//    5 CPU:     cpu_req
//    else idle (owner=0).
//  - Inputs are sampled only at arbitration; de falling mid-slot does not cancel the video slot, and
//    vid_load still pulses.
//  - A requester that drops its req before being granted is not acked. A DMA/CPU slot always completes
//    with an ack, even if req drops mid-slot.
//  - Acks/vid_load: registered pulses asserted at phase SLOT_CLKS-1 of the owning slot. Latency from
//    grant to ack = SLOT_CLKS-1 clocks after slot_start.
//  - ref_pend: +1 on a registered ihsync rising edge, saturating at REF_MAX. -1 at slot_start of a
//    refresh slot. Simultaneous +1 and -1 leaves it unchanged. Never below 0.
//  - A back-to-back requester may win consecutive slots; no fairness beyond the fixed priority.
// STRUCTURE
//  - Shared package gstmcu_slot_pkg: OWN_IDLE=2'd0, OWN_VID=2'd1, OWN_REF=2'd2, OWN_BUS=2'd3;
//    SLOT_CLKS and REF_MAX defaults.
//  - One sub-module, ref_pend_ctr: ihsync edge detect plus saturating up/down counter (inc, dec, count).
//  - Phase counter, arbiter and pulse generation stay in mem_slot_sched.
// TESTING
//  1 Reset release, all reqs 0, de=0: owner=0 every slot. slot_start every 4 clocks. No acks.
//  2 de=1, mde1=0, cpu_req=1: owner alternates VID/BUS(cpu). vid_load and cpu_ack each once per 8 clocks,
//    at phase 3.
//  3 de=1, mde1=1, dma_req=1: owner=VID every slot. dma_ack never asserted. Drop de -> DMA granted in the
//    next slot, dma_ack 3 clocks after its slot_start.
//  4 Three ihsync pulses with de=1, mde1=0, dma_req=1: ref_pend reaches 3. The next odd slot is a refresh
//    slot, ahead of DMA, and ref_pend returns to 2. A 4th ihsync at REF_MAX keeps ref_pend=3.
//  5 ihsync edge in the same clock as a refresh slot_start with ref_pend=1: ref_pend stays 1.
//  6 Assert por at phase 2 of a CPU slot: outputs 0 immediately. No cpu_ack is issued. After release,
//    the first slot_start occurs at the first clock.

Source files
------------

// File: rtl/gstmcu_slot_pkg.sv
// Shared constants for the memory-slot scheduler.
// Owner encodings and default slot geometry.
package gstmcu_slot_pkg;

  localparam int SLOT_CLKS_DEF = 4;
  localparam int REF_MAX_DEF   = 3;

  localparam logic [1:0] OWN_IDLE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_REF  = 2'd2;
  localparam logic [1:0] OWN_BUS  = 2'd3;

endpackage

// File: rtl/ref_pend_ctr.sv
// Pending-refresh counter: ihsync rising-edge detect
// feeding a saturating up/down counter.
module ref_pend_ctr #(
  parameter int W       = 2,
  parameter int REF_MAX = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ihsync_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] MAXV = W'(REF_MAX);

  logic         hs_q;
  logic         inc;
  logic [W-1:0] cnt_q, cnt_d;

  // Next count: inc and dec together cancel out.
  always_comb begin
    inc   = ihsync_i & ~hs_q;
    cnt_d = cnt_q;
    if (inc && !dec_i && cnt_q != MAXV)
      cnt_d = cnt_q + W'(1);
    else if (dec_i && !inc && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // Edge-detect flop and counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hs_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      hs_q  <= ihsync_i;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/mem_slot_sched.sv
// Memory-cycle scheduler: splits m2clock into fixed slots
// and grants each to video, refresh, DMA or CPU.
module mem_slot_sched
  import gstmcu_slot_pkg::*;
#(
  parameter int SLOT_CLKS = SLOT_CLKS_DEF,
  parameter int REF_MAX   = REF_MAX_DEF
) (
  input  logic       m2clock,
  input  logic       por,
  input  logic       de,
  input  logic       mde1,
  input  logic       ihsync,
  input  logic       dma_req,
  input  logic       cpu_req,
  output logic       slot_start,
  output logic [1:0] owner,
  output logic       dma_sel,
  output logic       vid_load,
  output logic       ref_grant,
  output logic       dma_ack,
  output logic       cpu_ack,
  output logic [1:0] ref_pend
);

  localparam int PW = (SLOT_CLKS > 2) ? $clog2(SLOT_CLKS) : 1;
  localparam logic [PW-1:0] LAST = PW'(SLOT_CLKS - 1);
  localparam logic [PW-1:0] PRE  = PW'(SLOT_CLKS - 2);
  localparam logic [1:0]    RMAX = 2'(REF_MAX);

  logic [PW-1:0] phase_q;
  logic          par_q;
  logic [1:0]    own_q, own_d;
  logic          sel_q, sel_d;
  logic          vid_q, dack_q, cack_q;
  logic          vid_d, dack_d, cack_d;
  logic          vid_ok, ref_dec;

  // Arbitrate at the last phase; hold the owner otherwise.
  always_comb begin
    own_d  = own_q;
    sel_d  = sel_q;
    vid_ok = de & (mde1 | par_q);
    if (phase_q == LAST) begin
      sel_d = 1'b0;
      if (vid_ok)
        own_d = OWN_VID;
      else if (ref_pend == RMAX)
        own_d = OWN_REF;
      else if (dma_req) begin
        own_d = OWN_BUS;
        sel_d = 1'b1;
      end else if (ref_pend != 2'd0 && !de)
        own_d = OWN_REF;
      else if (cpu_req)
        own_d = OWN_BUS;
      else
        own_d = OWN_IDLE;
    end
  end

  // Pulses land on the last phase of the owning slot.
  always_comb begin
    vid_d  = (phase_q == PRE) && (own_q == OWN_VID);
    dack_d = (phase_q == PRE) && (own_q == OWN_BUS) && sel_q;
    cack_d = (phase_q == PRE) && (own_q == OWN_BUS) && !sel_q;
  end

  // Phase counter, parity, owner and pulse registers.
  always_ff @(posedge m2clock or posedge por) begin
    if (por) begin
      phase_q <= '0;
      par_q   <= 1'b0;
      own_q   <= OWN_IDLE;
      sel_q   <= 1'b0;
      vid_q   <= 1'b0;
      dack_q  <= 1'b0;
      cack_q  <= 1'b0;
    end else begin
      phase_q <= phase_q + PW'(1);
      if (phase_q == LAST)
        par_q <= ~par_q;
      own_q   <= own_d;
      sel_q   <= sel_d;
      vid_q   <= vid_d;
      dack_q  <= dack_d;
      cack_q  <= cack_d;
    end
  end

  assign ref_dec = (phase_q == '0) && (own_q == OWN_REF);

  ref_pend_ctr #(
    .W       (2),
    .REF_MAX (REF_MAX)
  ) u_ref (
    .clk_i    (m2clock),
    .rst_i    (por),
    .ihsync_i (ihsync),
    .dec_i    (ref_dec),
    .count_o  (ref_pend)
  );

  assign slot_start = (phase_q == '0) & ~por;
  assign owner      = own_q;
  assign dma_sel    = sel_q;
  assign ref_grant  = (own_q == OWN_REF);
  assign vid_load   = vid_q;
  assign dma_ack    = dack_q;
  assign cpu_ack    = cack_q;

endmodule

// File: tb/tb_mem_slot_sched.sv
// Scoreboard bench for mem_slot_sched: slot-level model
// pushes expected owners, a monitor pops at slot_start.
module tb_mem_slot_sched;

  localparam int SC = 4;
  localparam int RM = 3;

  logic m2clock = 1'b0;
  logic por = 1'b1;
  logic de = 1'b0, mde1 = 1'b0, ihsync = 1'b0;
  logic dma_req = 1'b0, cpu_req = 1'b0;
  logic slot_start, dma_sel, vid_load, ref_grant;
  logic dma_ack, cpu_ack;
  logic [1:0] owner, ref_pend;

  mem_slot_sched dut (
    .m2clock    (m2clock),
    .por        (por),
    .de         (de),
    .mde1       (mde1),
    .ihsync     (ihsync),
    .dma_req    (dma_req),
    .cpu_req    (cpu_req),
    .slot_start (slot_start),
    .owner      (owner),
    .dma_sel    (dma_sel),
    .vid_load   (vid_load),
    .ref_grant  (ref_grant),
    .dma_ack    (dma_ack),
    .cpu_ack    (cpu_ack),
    .ref_pend   (ref_pend)
  );

  always #5 m2clock = ~m2clock;

  typedef struct packed {
    logic [1:0] own;
    logic       dma;
  } rec_t;

  int errors = 0;
  int checks = 0;
  rec_t q[$];

  int   m_phase, m_slot, m_pend;
  logic m_hs;
  rec_t m_cur;
  int   mon_k;
  rec_t mon_cur;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Priority rules, written straight from the slot policy.
  function automatic rec_t decide(int slot_next);
    rec_t r;
    r = '0;
    if (de && (mde1 || (slot_next % 2 == 0)))
      r.own = 2'd1;
    else if (m_pend == RM)
      r.own = 2'd2;
    else if (dma_req) begin
      r.own = 2'd3;
      r.dma = 1'b1;
    end else if (m_pend != 0 && !de)
      r.own = 2'd2;
    else if (cpu_req)
      r.own = 2'd3;
    return r;
  endfunction

  task automatic model_step();
    int inc, dec;
    rec_t nx;
    if (por) begin
      m_phase = 0;
      m_slot  = 0;
      m_pend  = 0;
      m_hs    = 1'b0;
      m_cur   = '0;
      q.delete();
      q.push_back('0);
    end else begin
      inc = (ihsync && !m_hs) ? 1 : 0;
      dec = (m_phase == 0 && m_cur.own == 2'd2) ? 1 : 0;
      if (m_phase == SC - 1) begin
        nx = decide(m_slot + 1);
        q.push_back(nx);
        m_cur = nx;
      end
      m_pend = m_pend + inc - dec;
      if (m_pend > RM) m_pend = RM;
      if (m_pend < 0) m_pend = 0;
      m_hs = ihsync;
      m_phase = (m_phase + 1) % SC;
      if (m_phase == 0) m_slot++;
    end
  endtask

  task automatic mon_step();
    if (por) begin
      chk("rst_owner", int'(owner), 0);
      chk("rst_dma_sel", int'(dma_sel), 0);
      chk("rst_vid_load", int'(vid_load), 0);
      chk("rst_dma_ack", int'(dma_ack), 0);
      chk("rst_cpu_ack", int'(cpu_ack), 0);
      chk("rst_ref_grant", int'(ref_grant), 0);
      chk("rst_ref_pend", int'(ref_pend), 0);
      mon_k   = SC - 1;
      mon_cur = '0;
    end else begin
      chk("slot_start", int'(slot_start),
          (mon_k == SC - 1) ? 1 : 0);
      if (slot_start) begin
        if (q.size() == 0) fail_now("queue_underflow");
        else mon_cur = q.pop_front();
        mon_k = 0;
      end else begin
        mon_k = (mon_k + 1) % SC;
      end
      chk("owner", int'(owner), int'(mon_cur.own));
      chk("dma_sel", int'(dma_sel), int'(mon_cur.dma));
      chk("ref_grant", int'(ref_grant),
          (mon_cur.own == 2'd2) ? 1 : 0);
      chk("vid_load", int'(vid_load),
          (mon_k == SC - 1 && mon_cur.own == 2'd1) ? 1 : 0);
      chk("dma_ack", int'(dma_ack),
          (mon_k == SC - 1 && mon_cur.own == 2'd3
           && mon_cur.dma) ? 1 : 0);
      chk("cpu_ack", int'(cpu_ack),
          (mon_k == SC - 1 && mon_cur.own == 2'd3
           && !mon_cur.dma) ? 1 : 0);
      chk("ref_pend", int'(ref_pend), m_pend);
    end
  endtask

  initial begin
    m_phase = 0; m_slot = 0; m_pend = 0;
    m_hs = 1'b0; m_cur = '0;
    forever begin
      @(posedge m2clock);
      model_step();
    end
  end

  initial begin
    mon_k = SC - 1;
    mon_cur = '0;
    forever begin
      @(negedge m2clock);
      mon_step();
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge m2clock);
      #1;
    end
  endtask

  task automatic pulse_hs();
    ihsync = 1'b1;
    tick(2);
    ihsync = 1'b0;
    tick(2);
  endtask

  initial begin
    int n;
    tick(3);
    por = 1'b0;

    // idle with everything low
    tick(24);

    // alternating video / cpu
    de = 1'b1; mde1 = 1'b0; cpu_req = 1'b1;
    tick(32);

    // mono video hogs every slot, then DMA after de drops
    cpu_req = 1'b0; mde1 = 1'b1; dma_req = 1'b1;
    tick(24);
    de = 1'b0;
    tick(12);

    // refresh becomes urgent and beats DMA
    de = 1'b1; mde1 = 1'b0; dma_req = 1'b1;
    repeat (3) pulse_hs();
    pulse_hs();
    tick(24);

    // inc and dec in the same clock
    dma_req = 1'b0; de = 1'b0;
    n = 0;
    while (m_pend != 0 && n < 100) begin tick(1); n++; end
    if (n >= 100) fail_now("timeout_drain");
    de = 1'b1; mde1 = 1'b1;
    pulse_hs();
    chk("t5_pend_one", int'(ref_pend), 1);
    de = 1'b0;
    n = 0;
    while (m_phase != SC - 1 && n < 20) begin tick(1); n++; end
    if (n >= 20) fail_now("timeout_phase");
    tick(1);
    ihsync = 1'b1;
    tick(1);
    ihsync = 1'b0;
    chk("t5_pend_hold", int'(ref_pend), 1);
    chk("t5_ref_grant", int'(ref_grant), 1);
    tick(12);

    // reset in the middle of a CPU slot
    de = 1'b0; cpu_req = 1'b1;
    n = 0;
    while (!(m_cur.own == 2'd3 && !m_cur.dma && m_phase == 2)
           && n < 80) begin
      tick(1); n++;
    end
    if (n >= 80) fail_now("timeout_cpu_slot");
    por = 1'b1;
    #1;
    chk("t6_owner_async", int'(owner), 0);
    tick(2);
    por = 1'b0;
    tick(12);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) de = ~de;
      if ($urandom_range(0, 63) == 0) mde1 = ~mde1;
      if ($urandom_range(0, 3) == 0) dma_req = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 3) == 0) cpu_req = $urandom_range(0, 1) == 1;
      ihsync = $urandom_range(0, 11) == 0;
      por = $urandom_range(0, 499) == 0;
      tick(1);
    end
    por = 1'b0;
    ihsync = 1'b0;
    tick(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
